// File: rtl/seg_value_formatter.sv
// Binary 0..9999 -> four 7-segment masks via sequential double-dabble, handed to the display driver.
// Optional macro SEG_COLON_EN adds colon_i, which drives digits_o[1][7].
module seg_value_formatter #(
  parameter bit BLANK_LEADING_ZEROS = 1'b1,
  parameter bit SKIP_UNCHANGED      = 1'b1
) (
  input  logic        clk_i,
  input  logic        porb_i,
  input  logic        sync_reset_i,
  input  logic [13:0] value_i,
  input  logic        value_valid_i,
`ifdef SEG_COLON_EN
  input  logic        colon_i,
`endif
  input  logic        busy_i,
  output logic [7:0]  digits_o [0:3],
  output logic        disp_strobe_o,
  output logic        ready_o,
  output logic        overflow_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_ENCODE,
    S_WAIT_DRV,
    S_STROBE
  } state_t;

  state_t          state_reg;
  logic            pend_reg;
  logic [13:0]     pend_val_reg;
  logic [29:0]     dd_reg;        // {bcd[15:0], binary[13:0]}
  logic [3:0]      step_reg;
  logic            ovf_reg;
  logic [3:0][7:0] enc_reg;
  logic [3:0][7:0] last_reg;
  logic [3:0][7:0] digits_reg;
  logic            strobe_reg;
  logic            overflow_reg;

  logic            capture;
  logic [15:0]     bcd_adj;
  logic [29:0]     dd_next;
  logic [3:0][7:0] enc_next;
  logic [3:0][7:0] enc_out;

  function automatic logic [7:0] seg_lut(input logic [3:0] d);
    case (d)
      4'd0:    seg_lut = 8'h3F;
      4'd1:    seg_lut = 8'h06;
      4'd2:    seg_lut = 8'h5B;
      4'd3:    seg_lut = 8'h4F;
      4'd4:    seg_lut = 8'h66;
      4'd5:    seg_lut = 8'h6D;
      4'd6:    seg_lut = 8'h7D;
      4'd7:    seg_lut = 8'h07;
      4'd8:    seg_lut = 8'h7F;
      4'd9:    seg_lut = 8'h6F;
      default: seg_lut = 8'h00;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      // Digit gi counts from the left, so its BCD nibble sits at dd_reg[29-4*gi -: 4].
      logic [3:0] bcd_digit;
      logic       lead_zero;
      assign bcd_digit = dd_reg[26-4*gi +: 4];
      assign lead_zero = (dd_reg[29 -: 4*(gi+1)] == '0);
      assign bcd_adj[4*gi +: 4] = (dd_reg[14+4*gi +: 4] >= 4'd5) ?
                                  dd_reg[14+4*gi +: 4] + 4'd3 : dd_reg[14+4*gi +: 4];
      assign enc_next[gi] = ovf_reg ? 8'h40 :
                            (BLANK_LEADING_ZEROS && (gi < 3) && lead_zero) ? 8'h00 :
                            seg_lut(bcd_digit);
      assign digits_o[gi] = digits_reg[gi];
    end
  endgenerate

  assign dd_next = {bcd_adj[14:0], dd_reg[13:0], 1'b0};

`ifdef SEG_COLON_EN
  logic colon_seen_reg;
  // A colon edge re-runs the pipeline so the new colon reaches the driver.
  assign capture = value_valid_i | (colon_i != colon_seen_reg);
  always_comb begin
    enc_out       = enc_reg;
    enc_out[1][7] = colon_i;
  end
`else
  assign capture = value_valid_i;
  assign enc_out = enc_reg;
`endif

  assign ready_o       = (state_reg == S_IDLE) && !pend_reg;
  assign disp_strobe_o = strobe_reg;
  assign overflow_o    = overflow_reg;

  always_ff @(posedge clk_i or negedge porb_i) begin
    if (!porb_i) begin
      state_reg    <= S_IDLE;
      pend_reg     <= 1'b0;
      pend_val_reg <= '0;
      dd_reg       <= '0;
      step_reg     <= '0;
      ovf_reg      <= 1'b0;
      enc_reg      <= '0;
      last_reg     <= '0;
      digits_reg   <= '0;
      strobe_reg   <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef SEG_COLON_EN
      colon_seen_reg <= 1'b0;
`endif
    end else if (sync_reset_i) begin
      state_reg    <= S_IDLE;
      pend_reg     <= 1'b0;
      pend_val_reg <= '0;
      dd_reg       <= '0;
      step_reg     <= '0;
      ovf_reg      <= 1'b0;
      enc_reg      <= '0;
      last_reg     <= '0;
      digits_reg   <= '0;
      strobe_reg   <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef SEG_COLON_EN
      colon_seen_reg <= 1'b0;
`endif
    end else begin
      strobe_reg <= 1'b0;
`ifdef SEG_COLON_EN
      colon_seen_reg <= colon_i;
`endif
      case (state_reg)
        S_IDLE: begin
          if (pend_reg) begin
            dd_reg    <= {16'd0, pend_val_reg};
            ovf_reg   <= (pend_val_reg > 14'd9999);
            step_reg  <= '0;
            pend_reg  <= 1'b0;
            state_reg <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          dd_reg   <= dd_next;
          step_reg <= step_reg + 4'd1;
          if (step_reg == 4'd13) state_reg <= S_ENCODE;
        end
        S_ENCODE: begin
          enc_reg   <= enc_next;
          state_reg <= S_WAIT_DRV;
        end
        S_WAIT_DRV: begin
          if (!busy_i) begin
            if (SKIP_UNCHANGED && (enc_out == last_reg)) begin
              state_reg <= S_IDLE;
            end else begin
              digits_reg   <= enc_out;
              last_reg     <= enc_out;
              overflow_reg <= ovf_reg;
              strobe_reg   <= 1'b1;
              state_reg    <= S_STROBE;
            end
          end
        end
        S_STROBE: state_reg <= S_IDLE;
        default:  state_reg <= S_IDLE;
      endcase
      // Placed after the FSM so a capture coinciding with IDLE's consume keeps pend set.
      if (capture) pend_reg <= 1'b1;
      if (value_valid_i) pend_val_reg <= value_i;
    end
  end

endmodule

// File: tb/tb_seg_value_formatter.sv
// Scoreboard bench for seg_value_formatter: stimulus pushes expected masks, a monitor checks each strobe.
module tb_seg_value_formatter;

  logic        clk_i = 1'b0;
  logic        porb_i;
  logic        sync_reset_i;
  logic [13:0] value_i;
  logic        value_valid_i;
  logic        busy_i;
  logic [7:0]  digits_o [0:3];
  logic        disp_strobe_o;
  logic        ready_o;
  logic        overflow_o;

  seg_value_formatter dut (
    .clk_i         (clk_i),
    .porb_i        (porb_i),
    .sync_reset_i  (sync_reset_i),
    .value_i       (value_i),
    .value_valid_i (value_valid_i),
`ifdef SEG_COLON_EN
    .colon_i       (1'b0),
`endif
    .busy_i        (busy_i),
    .digits_o      (digits_o),
    .disp_strobe_o (disp_strobe_o),
    .ready_o       (ready_o),
    .overflow_o    (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] digits;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   last_strobe_cyc = 0;
  int   issue_cyc = 0;

  always @(posedge clk_i) cyc++;

  function automatic logic [31:0] digits_packed();
    return {digits_o[0], digits_o[1], digits_o[2], digits_o[3]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    if (porb_i && disp_strobe_o) begin
      exp_t e;
      strobe_cnt++;
      last_strobe_cyc = cyc;
      $display("[TB] strobe digits=%08h ovf=%0b", digits_packed(), overflow_o);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_strobe: got digits %08h, expected no strobe", digits_packed());
      end else begin
        e = sb_q.pop_front();
        check("strobe_digits", digits_packed(), e.digits);
        check("strobe_overflow", {31'd0, overflow_o}, {31'd0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [13:0] v, input bit expect_strobe,
                      input logic [31:0] exp_d, input logic exp_o);
    exp_t e;
    if (expect_strobe) begin
      e.digits = exp_d;
      e.ovf    = exp_o;
      sb_q.push_back(e);
    end
    value_i       = v;
    value_valid_i = 1'b1;
    issue_cyc     = cyc;
    tick();
    value_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!(ready_o && sb_q.size() == 0) && n < 300) begin
      tick();
      n++;
    end
    // One extra cycle lets the monitor drain a strobe seen on the final edge.
    tick();
    if (n >= 300) begin
      tests++;
      fails++;
      $display("[TB] FAIL %s_timeout: got %0d pending, expected 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    int cnt0;
    logic [31:0] held;
    bit bad;
    porb_i        = 1'b0;
    sync_reset_i  = 1'b0;
    value_i       = '0;
    value_valid_i = 1'b0;
    busy_i        = 1'b0;
    repeat (3) tick();
    porb_i = 1'b1;
    tick();

    check("reset_digits", digits_packed(), 32'h0);
    check("reset_ready", {31'd0, ready_o}, 32'd1);
    check("reset_strobe", {31'd0, disp_strobe_o}, 32'd0);
    check("reset_overflow", {31'd0, overflow_o}, 32'd0);

    // 1: basic conversion and latency
    send(14'd1234, 1'b1, 32'h065B4F66, 1'b0);
    wait_done("v1234");
    check("latency_1234", last_strobe_cyc - issue_cyc, 32'd18);

    // 2: leading-zero blanking
    send(14'd7, 1'b1, 32'h00000007, 1'b0);
    wait_done("v7");
    send(14'd0, 1'b1, 32'h0000003F, 1'b0);
    wait_done("v0");

    // 3: overflow and recovery
    send(14'd12000, 1'b1, 32'h40404040, 1'b1);
    wait_done("v12000");
    check("overflow_held", {31'd0, overflow_o}, 32'd1);
    send(14'd9999, 1'b1, 32'h6F6F6F6F, 1'b0);
    wait_done("v9999");
    check("latency_9999", last_strobe_cyc - issue_cyc, 32'd18);

    // 4: driver busy stalls the hand-off
    busy_i = 1'b1;
    cnt0   = strobe_cnt;
    held   = digits_packed();
    send(14'd42, 1'b1, 32'h0000665B, 1'b0);
    bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (disp_strobe_o || digits_packed() != held) bad = 1'b1;
      tick();
    end
    check("busy_no_change", {31'd0, bad}, 32'd0);
    check("busy_strobe_cnt", strobe_cnt - cnt0, 32'd0);
    busy_i = 1'b0;
    tick();
    check("busy_release_strobe", {31'd0, disp_strobe_o}, 32'd1);
    wait_done("v42");

    // 5: back-to-back values, second arrives as the first is consumed
    cnt0 = strobe_cnt;
    send(14'd11, 1'b1, 32'h00000606, 1'b0);
    send(14'd22, 1'b1, 32'h00005B5B, 1'b0);
    wait_done("v11_22");
    repeat (40) tick();
    check("two_strobes_only", strobe_cnt - cnt0, 32'd2);
    check("final_22", digits_packed(), 32'h00005B5B);

    // 6: unchanged value is skipped
    send(14'd1234, 1'b1, 32'h065B4F66, 1'b0);
    wait_done("v1234b");
    cnt0 = strobe_cnt;
    send(14'd1234, 1'b0, 32'h0, 1'b0);
    wait_done("v1234_skip");
    check("skip_no_strobe", strobe_cnt - cnt0, 32'd0);
    check("skip_ready", {31'd0, ready_o}, 32'd1);

    // 6b: async reset mid-conversion discards the value
    cnt0 = strobe_cnt;
    send(14'd5555, 1'b0, 32'h0, 1'b0);
    repeat (5) tick();
    porb_i = 1'b0;
    #2;
    porb_i = 1'b1;
    repeat (40) tick();
    check("porb_no_strobe", strobe_cnt - cnt0, 32'd0);
    check("porb_digits", digits_packed(), 32'h0);
    check("porb_ready", {31'd0, ready_o}, 32'd1);
    check("porb_overflow", {31'd0, overflow_o}, 32'd0);

    // Sync reset behaves the same way
    cnt0 = strobe_cnt;
    send(14'd3210, 1'b1, 32'h4F5B063F, 1'b0);
    wait_done("v3210");
    send(14'd4321, 1'b0, 32'h0, 1'b0);
    repeat (6) tick();
    sync_reset_i = 1'b1;
    tick();
    sync_reset_i = 1'b0;
    repeat (40) tick();
    check("srst_strobe_cnt", strobe_cnt - cnt0, 32'd1);
    check("srst_digits", digits_packed(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
